simd_vec_mem_responder: RTL

- Memory-side responder for the 4-lane SIMD processor's LD/ST/VLD/VST traffic.
- Accepts one scalar or 128-bit vector request at a time.
- Serialises a vector request into four 32-bit beats against an internal word memory, then returns an assembled 128-bit response.
- Exposes its beat counter and the current write word, so benches can trace it alongside the processor's offset and mem-write debug signals.

---
 rtl/simd_vec_mem_responder_pkg.sv | 22 ++
 rtl/simd_vec_mem_responder_if.sv | 24 ++
 rtl/simd_vec_mem_responder_ram.sv | 22 ++
 rtl/simd_vec_mem_responder.sv | 102 ++++++++++
 4 files changed

// File: rtl/simd_vec_mem_responder_pkg.sv
// Shared widths, lane helpers and state encoding for the SIMD memory responder.
package simd_pkg;
    localparam int DATA_W = 32;
    localparam int LANES  = 4;
    localparam int VEC_W  = DATA_W * LANES;
    localparam int OFF_W  = 2;

    localparam logic [OFF_W-1:0] FIRST_LANE = '0;
    localparam logic [OFF_W-1:0] LAST_LANE  = OFF_W'(LANES - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BEAT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    // Extract 32-bit lane idx from a 128-bit vector.
    function automatic logic [DATA_W-1:0] lane_of(input logic [VEC_W-1:0] v,
                                                  input logic [OFF_W-1:0] idx);
        return v[idx*DATA_W +: DATA_W];
    endfunction
endpackage

// File: rtl/simd_vec_mem_responder_if.sv
// Request/response bus between the SIMD processor and the memory responder.
interface simd_vec_mem_responder_if #(parameter int ADDR_W = 4);
    import simd_pkg::*;

    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_vec;
    logic [ADDR_W-1:0] req_addr;
    logic [VEC_W-1:0]  req_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [VEC_W-1:0]  rsp_rdata;

    modport master (
        output req_valid, req_write, req_vec, req_addr, req_wdata, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata
    );

    modport slave (
        input  req_valid, req_write, req_vec, req_addr, req_wdata, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata
    );
endinterface

// File: rtl/simd_vec_mem_responder_ram.sv
// Word memory: asynchronous read, synchronous write, contents survive reset.
module simd_word_ram
    import simd_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];

    assign rdata = mem[addr];

    // Single write port, no reset so data is retained across reset.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wdata;
    end
endmodule

// File: rtl/simd_vec_mem_responder.sv
// Memory-side responder: serialises scalar/vector LD/ST into 32-bit beats
// against a local word RAM and returns an assembled 128-bit response.
module simd_vec_mem_responder
    import simd_pkg::*;
#(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    simd_vec_mem_responder_if.slave bus,
    output logic [OFF_W-1:0]       offset,
    output logic [DATA_W-1:0]      mem_write_data,
    output logic                   busy
);
    state_t            state, state_nxt;
    logic              wr_q, vec_q;
    logic [ADDR_W-1:0] addr_q;
    logic [VEC_W-1:0]  wdata_q;
    logic [VEC_W-1:0]  asm_q, asm_nxt;
    logic [VEC_W-1:0]  rdata_q;
    logic              accept, last_beat, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_wdata, ram_rdata;

    assign accept    = (state == ST_IDLE) && bus.req_valid;
    assign last_beat = vec_q ? (offset == LAST_LANE) : (offset == FIRST_LANE);
    // Narrow add wraps modulo DEPTH (15 -> 0 for a vector at the top).
    assign ram_addr  = addr_q + ADDR_W'(offset);
    assign ram_we    = (state == ST_BEAT) && wr_q;
    assign ram_wdata = lane_of(wdata_q, offset);

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.rsp_valid = (state == ST_RESP);
    assign bus.rsp_rdata = rdata_q;
    assign busy          = (state != ST_IDLE);
    assign mem_write_data = ram_we ? ram_wdata : '0;

    simd_word_ram #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .rdata (ram_rdata)
    );

    // Assembly register with the current beat's read word merged in.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[offset*DATA_W +: DATA_W] = ram_rdata;
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state decode.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: if (accept)        state_nxt = ST_BEAT;
            ST_BEAT: if (last_beat)     state_nxt = ST_RESP;
            ST_RESP: if (bus.rsp_ready) state_nxt = ST_IDLE;
            default:                    state_nxt = ST_IDLE;
        endcase
    end

    // Request latch, beat counter and response assembly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_q    <= 1'b0;
            vec_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            asm_q   <= '0;
            rdata_q <= '0;
            offset  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        wr_q    <= bus.req_write;
                        vec_q   <= bus.req_vec;
                        addr_q  <= bus.req_addr;
                        wdata_q <= bus.req_wdata;
                        asm_q   <= '0;
                        offset  <= '0;
                    end
                end
                ST_BEAT: begin
                    if (!wr_q) asm_q <= asm_nxt;
                    // rsp_rdata only moves on entry to RESP, never mid-burst.
                    if (last_beat) rdata_q <= wr_q ? '0 : asm_nxt;
                    else           offset  <= offset + 1'b1;
                end
                default: ;
            endcase
        end
    end
endmodule
